// File: rtl/expu_sum_acc.sv
// Converts bfloat16-style exp results to unsigned fixed point and sums each vector with saturation; EXPU_SUM_ACC_COUNT_EN adds a beat count.
// Latency: the sum is valid two cycles after the last beat is accepted; one result is held at a time.
// Backpressure: input stalls in DRAIN/HOLD and while enable_i=0; the result is held until ready_i & enable_i.
module expu_sum_acc #(
    parameter int EXPONENT_BITS = 8,
    parameter int MANTISSA_BITS = 7,
    parameter int ACC_INT_BITS  = 16,
    parameter int ACC_FRAC_BITS = 16
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   clear_i,
    input  logic                                   enable_i,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    input  logic [EXPONENT_BITS+MANTISSA_BITS:0]   op_i,
    input  logic                                   last_i,
    output logic                                   valid_o,
    input  logic                                   ready_i,
    output logic [ACC_INT_BITS+ACC_FRAC_BITS-1:0]  sum_o,
    output logic                                   sat_o,
    output logic                                   neg_o
`ifdef EXPU_SUM_ACC_COUNT_EN
    ,
    output logic [15:0]                            count_o
`endif
);

    localparam int OP_W   = EXPONENT_BITS + MANTISSA_BITS + 1;
    localparam int ACC_W  = ACC_INT_BITS + ACC_FRAC_BITS;
    localparam int BIAS   = (1 << (EXPONENT_BITS - 1)) - 1;
    localparam int SH_OFS = ACC_FRAC_BITS - MANTISSA_BITS - BIAS;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    state_t state, state_nxt;

    logic                     op_sign;
    logic [EXPONENT_BITS-1:0] op_exp;
    logic [MANTISSA_BITS:0]   op_sig;
    int                       shift;
    int                       msb_pos;
    logic [ACC_W-1:0]         conv_val;
    logic                     conv_sat;
    logic                     conv_neg;

    logic                     accept;
    logic                     out_hs;

    logic                     s1_vld;
    logic [ACC_W-1:0]         s1_val;
    logic                     s1_sat;
    logic                     s1_neg;

    logic [ACC_W-1:0]         acc;
    logic [ACC_W:0]           acc_sum;
    logic                     sat_flag;
    logic                     neg_flag;

    // Operand value is {1,mant} * 2^(exp-bias-mant_bits); msb_pos is where its leading one lands.
    always_comb begin
        op_sign  = op_i[OP_W-1];
        op_exp   = op_i[OP_W-2 -: EXPONENT_BITS];
        op_sig   = {1'b1, op_i[MANTISSA_BITS-1:0]};
        shift    = int'(op_exp) + SH_OFS;
        msb_pos  = shift + MANTISSA_BITS;
        conv_val = '0;
        conv_sat = 1'b0;
        conv_neg = 1'b0;
        if (op_exp == '1) begin
            conv_sat = 1'b1;
        end else if (op_exp != '0) begin
            if (op_sign) begin
                conv_neg = 1'b1;
            end else if (msb_pos >= ACC_W) begin
                conv_sat = 1'b1;
            end else if (shift >= 0) begin
                conv_val = ACC_W'(op_sig) << shift;
            end else begin
                conv_val = ACC_W'(op_sig >> (-shift));
            end
        end
    end

    assign ready_o = rst_ni & enable_i & (state != DRAIN) & (state != HOLD);
    assign accept  = valid_i & ready_o;
    assign out_hs  = enable_i & ready_i & (state == HOLD);
    assign acc_sum = {1'b0, acc} + {1'b0, s1_val};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        valid_o   = (state == HOLD);
        case (state)
            IDLE:    if (accept) state_nxt = last_i ? DRAIN : ACCUM;
            ACCUM:   if (accept && last_i) state_nxt = DRAIN;
            DRAIN:   if (enable_i) state_nxt = HOLD;
            HOLD:    if (out_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear_i) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld   <= 1'b0;
            s1_val   <= '0;
            s1_sat   <= 1'b0;
            s1_neg   <= 1'b0;
            acc      <= '0;
            sat_flag <= 1'b0;
            neg_flag <= 1'b0;
        end else if (clear_i) begin
            s1_vld   <= 1'b0;
            s1_val   <= '0;
            s1_sat   <= 1'b0;
            s1_neg   <= 1'b0;
            acc      <= '0;
            sat_flag <= 1'b0;
            neg_flag <= 1'b0;
        end else if (enable_i) begin
            s1_vld <= accept;
            if (accept) begin
                s1_val <= conv_val;
                s1_sat <= conv_sat;
                s1_neg <= conv_neg;
            end
            // No beat is in stage 1 during HOLD, so the handshake clear never races an add.
            if (out_hs) begin
                acc      <= '0;
                sat_flag <= 1'b0;
                neg_flag <= 1'b0;
            end else if (s1_vld) begin
                if (s1_sat || acc_sum[ACC_W]) begin
                    acc      <= '1;
                    sat_flag <= 1'b1;
                end else begin
                    acc <= acc_sum[ACC_W-1:0];
                end
                if (s1_neg) begin
                    neg_flag <= 1'b1;
                end
            end
        end
    end

    assign sum_o = acc;
    assign sat_o = sat_flag;
    assign neg_o = neg_flag;

`ifdef EXPU_SUM_ACC_COUNT_EN
    logic [15:0] beat_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt <= '0;
        end else if (clear_i) begin
            beat_cnt <= '0;
        end else if (enable_i) begin
            if (out_hs) begin
                beat_cnt <= '0;
            end else if (accept && (beat_cnt != '1)) begin
                beat_cnt <= beat_cnt + 16'd1;
            end
        end
    end

    assign count_o = beat_cnt;
`endif

endmodule

// File: tb/tb_expu_sum_acc.sv
// Bench for expu_sum_acc: directed vector table, hand-written corner sequences and randomized vectors vs a real-arithmetic model.
module tb_expu_sum_acc;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op;
    logic        last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        sat;
    logic        neg;
`ifdef EXPU_SUM_ACC_COUNT_EN
    logic [15:0] count;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [15:0] vq[$];

    expu_sum_acc dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clear_i  (clear),
        .enable_i (enable),
        .valid_i  (in_valid),
        .ready_o  (in_ready),
        .op_i     (op),
        .last_i   (last),
        .valid_o  (out_valid),
        .ready_i  (out_ready),
        .sum_o    (sum),
        .sat_o    (sat),
        .neg_o    (neg)
`ifdef EXPU_SUM_ACC_COUNT_EN
        ,
        .count_o  (count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
        end
    endtask

    // Reference: operand value as a real number, scaled by 2^16 and truncated.
    function automatic void model_vec(output logic [31:0] es, output bit esat, output bit eneg);
        longint tot;
        tot  = 0;
        esat = 0;
        eneg = 0;
        foreach (vq[i]) begin
            int  e;
            int  m;
            real r;
            e = int'(vq[i][14:7]);
            m = int'(vq[i][6:0]);
            if (e == 255) begin
                esat = 1;
            end else if (e != 0) begin
                if (vq[i][15]) begin
                    eneg = 1;
                end else begin
                    r = (128.0 + m) * (2.0 ** (e - 134)) * 65536.0;
                    if (r >= 4294967296.0) esat = 1;
                    else tot += longint'($floor(r));
                end
            end
        end
        if (tot > 64'hFFFF_FFFF) esat = 1;
        es = esat ? 32'hFFFF_FFFF : tot[31:0];
    endfunction

    function automatic logic [15:0] rand_op();
        int         r;
        logic [6:0] m;
        r = $urandom_range(0, 19);
        m = 7'($urandom);
        if (r == 0) return {1'b0, 8'h00, m};
        if (r == 1) return {1'b0, 8'hFF, m};
        if (r <= 3) return {1'b1, 8'($urandom_range(110, 140)), m};
        return {1'b0, 8'($urandom_range(100, 142)), m};
    endfunction

    // Sends vq as one vector from a negedge, checks latency and result, holds it for `hold` cycles, then handshakes.
    task automatic run_vec(input string nm, input logic [31:0] es, input bit esat, input bit eneg,
                           input int stall_after, input int stall_len, input int hold);
        int          drive_cyc;
        int          waited;
        int          exp_lat;
        logic [31:0] s0;
        drive_cyc = 0;
        exp_lat   = 2;
        for (int i = 0; i < vq.size(); i++) begin
            in_valid = 1'b1;
            op       = vq[i];
            last     = (i == vq.size() - 1);
            #1;
            chk($sformatf("%s in_ready beat%0d", nm, i), 32'(in_ready), 32'd1);
            drive_cyc = cyc;
            @(negedge clk);
            if (i == stall_after) begin
                if (i == vq.size() - 1) exp_lat += stall_len;
                enable   = 1'b0;
                in_valid = 1'b1;
                op       = 16'h7F80;
                last     = 1'b1;
                for (int s = 0; s < stall_len; s++) begin
                    #1;
                    chk($sformatf("%s stall in_ready", nm), 32'(in_ready), 32'd0);
                    @(negedge clk);
                end
                enable   = 1'b1;
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        last     = 1'b0;
        op       = 16'h0;
        waited   = 0;
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!out_valid) begin
            chk($sformatf("%s valid_o timeout", nm), 32'(out_valid), 32'd1);
            return;
        end
        chk($sformatf("%s latency", nm), 32'(cyc - drive_cyc), 32'(exp_lat));
        chk($sformatf("%s sum_o", nm), sum, es);
        chk($sformatf("%s sat_o", nm), 32'(sat), 32'(esat));
        chk($sformatf("%s neg_o", nm), 32'(neg), 32'(eneg));
`ifdef EXPU_SUM_ACC_COUNT_EN
        chk($sformatf("%s count_o", nm), 32'(count), 32'(vq.size()));
`endif
        s0 = sum;
        for (int h = 0; h < hold; h++) begin
            chk($sformatf("%s hold valid_o", nm), 32'(out_valid), 32'd1);
            chk($sformatf("%s hold ready_o", nm), 32'(in_ready), 32'd0);
            chk($sformatf("%s hold sum_o", nm), sum, s0);
            // A ready_i with enable_i low must not complete the handshake.
            if (h == 1 && hold >= 3) begin
                enable    = 1'b0;
                out_ready = 1'b1;
            end else begin
                enable    = 1'b1;
                out_ready = 1'b0;
            end
            @(negedge clk);
        end
        enable    = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("%s valid_o after handshake", nm), 32'(out_valid), 32'd0);
    endtask

    typedef struct packed {
        logic [2:0]        n;
        logic [0:3][15:0]  ops;
        logic [31:0]       sum;
        logic              sat;
        logic              neg;
    } vec_t;

    vec_t        tbl[8];
    logic [31:0] es;
    bit          esat;
    bit          eneg;
    int          n;
    int          st_after;

    initial begin
        tbl[0] = '{n: 3'd4, ops: {16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80}, sum: 32'h0004_0000, sat: 1'b0, neg: 1'b0};
        tbl[1] = '{n: 3'd3, ops: {16'h3F00, 16'h4000, 16'h0000, 16'h0000}, sum: 32'h0002_8000, sat: 1'b0, neg: 1'b0};
        tbl[2] = '{n: 3'd1, ops: {16'h3700, 16'h0000, 16'h0000, 16'h0000}, sum: 32'h0000_0000, sat: 1'b0, neg: 1'b0};
        tbl[3] = '{n: 3'd1, ops: {16'h4780, 16'h0000, 16'h0000, 16'h0000}, sum: 32'hFFFF_FFFF, sat: 1'b1, neg: 1'b0};
        tbl[4] = '{n: 3'd1, ops: {16'h7F80, 16'h0000, 16'h0000, 16'h0000}, sum: 32'hFFFF_FFFF, sat: 1'b1, neg: 1'b0};
        tbl[5] = '{n: 3'd2, ops: {16'hBF80, 16'h3F80, 16'h0000, 16'h0000}, sum: 32'h0001_0000, sat: 1'b0, neg: 1'b1};
        tbl[6] = '{n: 3'd1, ops: {16'h477F, 16'h0000, 16'h0000, 16'h0000}, sum: 32'hFF00_0000, sat: 1'b0, neg: 1'b0};
        tbl[7] = '{n: 3'd2, ops: {16'h477F, 16'h477F, 16'h0000, 16'h0000}, sum: 32'hFFFF_FFFF, sat: 1'b1, neg: 1'b0};

        rst_n     = 1'b0;
        clear     = 1'b0;
        enable    = 1'b1;
        in_valid  = 1'b0;
        op        = 16'h0;
        last      = 1'b0;
        out_ready = 1'b0;

        @(negedge clk);
        chk("reset valid_o", 32'(out_valid), 32'd0);
        chk("reset ready_o", 32'(in_ready), 32'd0);
        chk("reset sum_o", sum, 32'd0);
        chk("reset sat_o", 32'(sat), 32'd0);
        chk("reset neg_o", 32'(neg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 8; t++) begin
            vq.delete();
            for (int k = 0; k < int'(tbl[t].n); k++) vq.push_back(tbl[t].ops[k]);
            run_vec($sformatf("tbl%0d", t), tbl[t].sum, tbl[t].sat, tbl[t].neg, -1, 0, 0);
        end

        vq = '{16'h3F80, 16'h4000};
        run_vec("backpressure", 32'h0003_0000, 1'b0, 1'b0, -1, 0, 5);
        vq = '{16'h3F00};
        run_vec("after_backpressure", 32'h0000_8000, 1'b0, 1'b0, -1, 0, 0);

        vq = '{16'h3F80, 16'h3F80};
        run_vec("stall_last", 32'h0002_0000, 1'b0, 1'b0, 1, 3, 0);
        vq = '{16'h3F80, 16'h3F80, 16'h3F80};
        run_vec("stall_mid", 32'h0003_0000, 1'b0, 1'b0, 0, 3, 1);

        // Clear mid-vector, including a last beat offered in the clear cycle.
        in_valid = 1'b1;
        op       = 16'h3F80;
        last     = 1'b0;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        op    = 16'h4780;
        last  = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        last     = 1'b0;
        repeat (3) @(negedge clk);
        chk("clear valid_o", 32'(out_valid), 32'd0);
        chk("clear sum_o", sum, 32'd0);
        vq = '{16'h3F80};
        run_vec("after_clear", 32'h0001_0000, 1'b0, 1'b0, -1, 0, 0);

        // Clear while a result is pending, with ready_i high in the same cycle.
        in_valid = 1'b1;
        op       = 16'h4000;
        last     = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        last     = 1'b0;
        @(negedge clk);
        chk("pending valid_o", 32'(out_valid), 32'd1);
        clear     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        out_ready = 1'b0;
        chk("clear_hold valid_o", 32'(out_valid), 32'd0);
        vq = '{16'h3F00};
        run_vec("after_clear_hold", 32'h0000_8000, 1'b0, 1'b0, -1, 0, 0);

        // Reset asserted mid-vector after a saturating beat.
        in_valid = 1'b1;
        op       = 16'h4780;
        last     = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset valid_o", 32'(out_valid), 32'd0);
        chk("midreset ready_o", 32'(in_ready), 32'd0);
        chk("midreset sum_o", sum, 32'd0);
        chk("midreset sat_o", 32'(sat), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vq = '{16'h3F80};
        run_vec("after_reset", 32'h0001_0000, 1'b0, 1'b0, -1, 0, 0);

        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(1, 6);
            vq.delete();
            for (int k = 0; k < n; k++) vq.push_back(rand_op());
            model_vec(es, esat, eneg);
            st_after = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            run_vec($sformatf("rnd%0d", t), es, esat, eneg, st_after,
                    int'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
